axi4_stream_64b_16b_gbx: RTL and testbench
==========================================

# axi4_stream_64b_16b_gbx

AXI4-Stream width down-converter: accepts 64-bit beats and emits them as up to four 16-bit beats, lane 0 (bits 15:0) first. It sits on the frame buffer read path and is the counterpart of the 16b→64b write-side packer. It restores the narrow stream, including frame-start (tuser) and line-end (tlast) markers, with no bubbles between beats.

## Interface
- Parameters: none.
  - pkt_i widths: tdata 64, tkeep/tstrb 8, tuser/tdest/tid 1.
  - pkt_o widths: tdata 16, tkeep/tstrb 2, tuser/tdest/tid 1.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- pkt_i  axi4_stream_if.slave  64b  wide input stream.
- pkt_o  axi4_stream_if.master  16b  narrow output stream.

## Operation
- Holding buffer: one 64b entry, flag buf_vld.
  - Registers: data, keep, strb, tuser, tdest, tid, tlast.
  - Lane pointer rd_pos[1:0].
  - Last-lane index last_pos[1:0], computed at load.
- Load:
  - On pkt_i handshake: buf_vld<=1, rd_pos<=first lane to emit (0 in base mode), capture all fields, compute last_pos.
  - last_pos on a non-tlast beat: 3.
  - last_pos on a tlast beat: highest lane with a nonzero tkeep pair.
  - tlast beat with tkeep==8'h00: last_pos=0.
- Output (driven from registers through a lane mux, no combinational path from pkt_i):
  - pkt_o.tvalid = buf_vld.
  - tdata/tkeep/tstrb = lane rd_pos of the buffer.
  - tuser = buf.tuser && lane is the first emitted lane of the beat.
  - tlast = buf.tlast && rd_pos==last_pos.
  - tdest/tid = buffer copies.
- Advance on pkt_o handshake:
  - If rd_pos != last_pos: rd_pos<=next lane to emit.
  - Else: beat done. buf_vld<=0 unless a new beat loads in the same cycle.
- pkt_i.tready = !buf_vld || (pkt_o.tready && rd_pos==last_pos).
  - Simultaneous drain of the final lane and load of a new beat is legal and required. Load wins.
- Lanes after last_pos in a tlast beat are discarded.
- Beats are never merged across tlast. The next packet starts at lane 0 of its own beat.

## Timing
- Reset values:
  - buf_vld=0, so pkt_o.tvalid=0 and pkt_i.tready=1.
  - rd_pos=0, last_pos=0.
  - All buffered fields 0, so pkt_o.tdata/tkeep/tstrb/tuser/tlast/tdest/tid read 0.
- Latency: pkt_i handshake in cycle N → first narrow beat valid in cycle N+1.
- Throughput: with pkt_o.tready held 1, each full beat occupies exactly 4 output cycles, back to back, no idle cycle between input beats.
- Short tlast beat: occupies last_pos+1 cycles.
- Backpressure: pkt_o.tready=0 holds every pkt_o field stable and holds pkt_i.tready=0 while buf_vld=1.
- Reset asserted mid-beat: buffer cleared asynchronously and the partial beat is dropped. No output resumes until a new pkt_i handshake.

## Configuration
- Macro: AXI4_STREAM_64B_16B_GBX_SPARSE_EN.
- Defined:
  - Lanes whose tkeep pair is 2'b00 are skipped in every beat. "Next lane to emit" means the next lane with nonzero keep.
  - First lane of a beat is the lowest nonzero-keep lane. last_pos is the highest nonzero-keep lane for every beat.
  - A beat with tkeep==8'h00 and tlast=0 is consumed with no output. buf_vld stays 0 and tready stays 1.
  - A beat with tkeep==8'h00 and tlast=1 emits one lane-0 beat, tkeep=2'b00, tlast=1.
  - tuser is attached to the first emitted lane.
- Undefined:
  - Lanes 0..last_pos are emitted unconditionally, including interior zero-keep lanes, which pass with their keep value.

## Test plan
- Reset then idle: pkt_o.tvalid=0, pkt_i.tready=1, all pkt_o fields 0.
- Single beat 64'h4444_3333_2222_1111, tkeep FF, tuser 1, tlast 1, with pkt_o.tready=1:
  - Outputs 1111, 2222, 3333, 4444 on cycles N+1..N+4.
  - tuser=1 only on 1111; tlast=1 only on 4444.
- Three back-to-back beats, tlast on the third, with pkt_o.tready=1:
  - 12 contiguous output beats, no gap.
  - pkt_i.tready pulses high on every 4th cycle.
- tlast beat with tkeep 8'h0F, data 64'hDDDD_CCCC_BBBB_AAAA:
  - Only AAAA, BBBB emitted; tlast on BBBB.
  - Next beat accepted during the BBBB handshake.
- Random pkt_o.tready (50%) over 1000 beats: output equals the reference-model lane sequence, and fields are stable while tvalid && !tready.
- SPARSE_EN defined, tkeep 8'b1100_0011, tlast 1, data lanes 1111/2222/3333/4444:
  - Outputs 1111 then 4444; tlast on 4444.
  - A tkeep 8'h00, tlast 0 beat produces no output.

Source files
------------

// File: rtl/axi4_stream_64b_16b_gbx_if.sv
// AXI4-Stream bundle shared by the frame buffer read and write paths.
// DATA_W selects the tdata width; tkeep/tstrb carry one bit per byte.
interface axi4_stream_if #(
    parameter int DATA_W = 64
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tuser;
    logic              tlast;
    logic              tdest;
    logic              tid;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tuser, tlast, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tuser, tlast, tdest, tid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_64b_16b_gbx.sv
// AXI4-Stream 64b -> 16b gearbox for the frame buffer read path.
// One 64-bit beat is held and replayed as up to four 16-bit lanes, lane 0
// first, with tuser on the first emitted lane and tlast on the last lane of
// a tlast beat. A new wide beat loads in the same cycle the final lane
// drains, so a full stream runs with no bubbles.
// Optional feature macro: AXI4_STREAM_64B_16B_GBX_SPARSE_EN -- when defined,
// lanes whose tkeep pair is zero are skipped and all-null non-tlast beats are
// swallowed.
module axi4_stream_64b_16b_gbx (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);

    // Holding buffer and lane bookkeeping
    logic        buf_vld;
    logic        buf_first;
    logic [63:0] buf_data;
    logic [7:0]  buf_keep;
    logic [7:0]  buf_strb;
    logic        buf_user;
    logic        buf_last;
    logic        buf_dest;
    logic        buf_id;
    logic [1:0]  rd_pos;
    logic [1:0]  last_pos;

    logic        in_fire;
    logic        out_fire;
    logic        at_last;
    logic        in_skip;
    logic [1:0]  load_first;
    logic [1:0]  load_last;
    logic [1:0]  next_pos;

    // Highest lane whose keep pair is nonzero; lane 0 when the beat is null.
    function automatic logic [1:0] highest_lane(input logic [7:0] keep);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (keep[2*i +: 2] != 2'b00) lane = 2'(i);
        end
        return lane;
    endfunction

`ifdef AXI4_STREAM_64B_16B_GBX_SPARSE_EN
    // Lowest lane whose keep pair is nonzero; lane 0 when the beat is null.
    function automatic logic [1:0] lowest_lane(input logic [7:0] keep);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (keep[2*i +: 2] != 2'b00) lane = 2'(i);
        end
        return lane;
    endfunction

    // Next populated lane above pos; only asked for when pos != last_pos,
    // so a populated lane above pos always exists.
    function automatic logic [1:0] next_lane(input logic [7:0] keep,
                                             input logic [1:0] pos);
        logic [1:0] lane;
        lane = pos;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(pos) && keep[2*i +: 2] != 2'b00) lane = 2'(i);
        end
        return lane;
    endfunction
`endif

    assign at_last      = (rd_pos == last_pos);
    assign pkt_i.tready = !buf_vld || (pkt_o.tready && at_last);
    assign in_fire      = pkt_i.tvalid && pkt_i.tready;
    assign out_fire     = buf_vld && pkt_o.tready;

    // Lane selection for an incoming beat and the lane after rd_pos
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        load_first = 2'd0;
        load_last  = 2'd3;
        in_skip    = 1'b0;
        next_pos   = rd_pos + 2'd1;
`ifdef AXI4_STREAM_64B_16B_GBX_SPARSE_EN
        load_first = lowest_lane(pkt_i.tkeep);
        load_last  = highest_lane(pkt_i.tkeep);
        in_skip    = (pkt_i.tkeep == 8'h00) && !pkt_i.tlast;
        next_pos   = next_lane(buf_keep, rd_pos);
`else
        if (pkt_i.tlast) load_last = highest_lane(pkt_i.tkeep);
`endif
    end

    // Buffer load on input handshake, lane advance on output handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the data buffer is reset too because its fields are visible on pkt_o while idle.
            buf_vld   <= 1'b0;
            buf_first <= 1'b0;
            buf_data  <= '0;
            buf_keep  <= '0;
            buf_strb  <= '0;
            buf_user  <= 1'b0;
            buf_last  <= 1'b0;
            buf_dest  <= 1'b0;
            buf_id    <= 1'b0;
            rd_pos    <= 2'd0;
            last_pos  <= 2'd0;
        end else if (in_fire) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            buf_vld   <= !in_skip;
            buf_first <= 1'b1;
            buf_data  <= pkt_i.tdata;
            buf_keep  <= pkt_i.tkeep;
            buf_strb  <= pkt_i.tstrb;
            buf_user  <= pkt_i.tuser;
            buf_last  <= pkt_i.tlast;
            buf_dest  <= pkt_i.tdest;
            buf_id    <= pkt_i.tid;
            rd_pos    <= load_first;
            last_pos  <= load_last;
        end else if (out_fire) begin
            buf_first <= 1'b0;
            if (at_last) buf_vld <= 1'b0;
            else         rd_pos  <= next_pos;
        end
    end

    // Narrow output lane mux, driven only from the buffer registers
    always_comb begin
        pkt_o.tvalid = buf_vld;
        pkt_o.tdata  = buf_data[{rd_pos, 4'h0} +: 16];
        pkt_o.tkeep  = buf_keep[{rd_pos, 1'b0} +: 2];
        pkt_o.tstrb  = buf_strb[{rd_pos, 1'b0} +: 2];
        pkt_o.tuser  = buf_user && buf_first;
        pkt_o.tlast  = buf_last && at_last;
        pkt_o.tdest  = buf_dest;
        pkt_o.tid    = buf_id;
    end

endmodule

// File: tb/tb_axi4_stream_64b_16b_gbx.sv
// Self-checking bench for axi4_stream_64b_16b_gbx: directed steps plus a
// randomized backpressure run, with a lane scoreboard fed at input handshake.
module tb_axi4_stream_64b_16b_gbx;

    logic clk = 1'b0;
    logic rst;

    axi4_stream_if #(.DATA_W(64)) in_if ();
    axi4_stream_if #(.DATA_W(16)) out_if ();

    axi4_stream_64b_16b_gbx dut (
        .clk_i (clk),
        .rst_i (rst),
        .pkt_i (in_if.slave),
        .pkt_o (out_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic [1:0]  strb;
        logic        user;
        logic        last;
        logic        dest;
        logic        id;
    } lane_t;

    lane_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  stall_prev = 1'b0;
    lane_t held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic lane_t out_lane();
        lane_t l;
        l.data = out_if.tdata;
        l.keep = out_if.tkeep;
        l.strb = out_if.tstrb;
        l.user = out_if.tuser;
        l.last = out_if.tlast;
        l.dest = out_if.tdest;
        l.id   = out_if.tid;
        return l;
    endfunction

    // Reference model: expand one wide beat into the narrow lanes it must produce
    task automatic push_model(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                              input logic u, input logic l, input logic de, input logic id);
        lane_t e;
        int    lanes[$];
        for (int i = 0; i < 4; i++) begin
`ifdef AXI4_STREAM_64B_16B_GBX_SPARSE_EN
            if (k[2*i +: 2] != 2'b00) lanes.push_back(i);
`else
            lanes.push_back(i);
`endif
        end
`ifndef AXI4_STREAM_64B_16B_GBX_SPARSE_EN
        if (l) begin
            while (lanes.size() > 1 && k[2*lanes[lanes.size()-1] +: 2] == 2'b00)
                void'(lanes.pop_back());
        end
`else
        if (lanes.size() == 0 && l) lanes.push_back(0);
`endif
        for (int j = 0; j < lanes.size(); j++) begin
            e.data = d[16*lanes[j] +: 16];
            e.keep = k[2*lanes[j] +: 2];
            e.strb = s[2*lanes[j] +: 2];
            e.user = u && (j == 0);
            e.last = l && (j == lanes.size() - 1);
            e.dest = de;
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        lane_t cur;
        if (!rst) begin
            if (in_if.tvalid && in_if.tready)
                push_model(in_if.tdata, in_if.tkeep, in_if.tstrb, in_if.tuser,
                           in_if.tlast, in_if.tdest, in_if.tid);
            if (out_if.tvalid) begin
                cur = out_lane();
                if (stall_prev) check("hold_stable", 64'(cur), 64'(held));
                if (out_if.tready) begin
                    if (exp_q.size() == 0) check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                    else check("lane", 64'(cur), 64'(exp_q.pop_front()));
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    held       = cur;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic u,
                              input logic l);
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tstrb  = k;
        in_if.tuser  = u;
        in_if.tlast  = l;
        in_if.tdest  = d[0];
        in_if.tid    = d[1];
        in_if.tvalid = 1'b1;
    endtask

    // Wait for the current input beat to be accepted; returns just after that edge
    task automatic wait_accept(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_if.tvalid && in_if.tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check({"accept_", tag}, 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_if.tvalid) ok = 1'b1;
        end
        check({"drain_", tag}, 64'(ok), 64'd1);
    endtask

    initial begin
        logic [63:0] b3[3];
        logic        acc;
        int          idx;
        int          sent;
        logic [15:0] t2_exp[4];

        rst           = 1'b1;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tkeep   = '0;
        in_if.tstrb   = '0;
        in_if.tuser   = 1'b0;
        in_if.tlast   = 1'b0;
        in_if.tdest   = 1'b0;
        in_if.tid     = 1'b0;
        out_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
        check("rst_tready", 64'(in_if.tready), 64'd1);
        check("rst_tdata",  64'(out_if.tdata), 64'd0);
        check("rst_tkeep",  64'(out_if.tkeep), 64'd0);
        check("rst_tstrb",  64'(out_if.tstrb), 64'd0);
        check("rst_tuser",  64'(out_if.tuser), 64'd0);
        check("rst_tlast",  64'(out_if.tlast), 64'd0);
        check("rst_tdest",  64'(out_if.tdest), 64'd0);
        check("rst_tid",    64'(out_if.tid), 64'd0);
        @(posedge clk);
        #1;

        // Single full beat with tuser and tlast
        out_if.tready = 1'b1;
        t2_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        drive_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1);
        wait_accept("single");
        in_if.tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("single_valid", 64'(out_if.tvalid), 64'd1);
            check("single_data",  64'(out_if.tdata), 64'(t2_exp[k]));
            check("single_user",  64'(out_if.tuser), 64'(k == 0));
            check("single_last",  64'(out_if.tlast), 64'(k == 3));
        end
        @(negedge clk);
        check("single_idle", 64'(out_if.tvalid), 64'd0);
        @(posedge clk);
        #1;

        // Three back-to-back beats, tlast on the third
        b3 = '{64'h0A03_0A02_0A01_0A00, 64'h0B03_0B02_0B01_0B00, 64'h0C03_0C02_0C01_0C00};
        drive_beat(b3[0], 8'hFF, 1'b1, 1'b0);
        wait_accept("b2b_first");
        idx = 1;
        drive_beat(b3[1], 8'hFF, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("b2b_valid", 64'(out_if.tvalid), 64'd1);
            check("b2b_in_ready", 64'(in_if.tready), 64'(c % 4 == 3));
            acc = in_if.tvalid && in_if.tready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) drive_beat(b3[idx], 8'hFF, 1'b0, idx == 2);
                else in_if.tvalid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", 64'(out_if.tvalid), 64'd0);
        check("b2b_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Short tlast beat, next beat accepted during the final lane
        drive_beat(64'hDDDD_CCCC_BBBB_AAAA, 8'h0F, 1'b0, 1'b1);
        wait_accept("short");
        drive_beat(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        check("short_lane0",     64'(out_if.tdata), 64'hAAAA);
        check("short_lane0_last", 64'(out_if.tlast), 64'd0);
        check("short_lane0_rdy", 64'(in_if.tready), 64'd0);
        @(negedge clk);
        check("short_lane1",     64'(out_if.tdata), 64'hBBBB);
        check("short_lane1_last", 64'(out_if.tlast), 64'd1);
        check("short_lane1_keep", 64'(out_if.tkeep), 64'h3);
        check("short_lane1_rdy", 64'(in_if.tready), 64'd1);
        @(posedge clk);
        #1 in_if.tvalid = 1'b0;
        @(negedge clk);
        check("short_next_valid", 64'(out_if.tvalid), 64'd1);
        check("short_next_data",  64'(out_if.tdata), 64'h5555);
        check("short_next_user",  64'(out_if.tuser), 64'd1);
        wait_drain("short");
        @(posedge clk);
        #1;

        // Reset asserted mid-beat drops the partial beat
        drive_beat(64'h9999_9999_9999_9999, 8'hFF, 1'b0, 1'b1);
        wait_accept("midrst");
        in_if.tvalid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_if.tvalid), 64'd0);
        check("midrst_ready", 64'(in_if.tready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_quiet", 64'(out_if.tvalid), 64'd0);
        end
        @(posedge clk);
        #1;

`ifdef AXI4_STREAM_64B_16B_GBX_SPARSE_EN
        // Sparse lanes are skipped
        drive_beat(64'h4444_3333_2222_1111, 8'b1100_0011, 1'b1, 1'b1);
        wait_accept("sparse");
        in_if.tvalid = 1'b0;
        @(negedge clk);
        check("sparse_lane_a", 64'(out_if.tdata), 64'h1111);
        check("sparse_user_a", 64'(out_if.tuser), 64'd1);
        check("sparse_last_a", 64'(out_if.tlast), 64'd0);
        @(negedge clk);
        check("sparse_lane_b", 64'(out_if.tdata), 64'h4444);
        check("sparse_user_b", 64'(out_if.tuser), 64'd0);
        check("sparse_last_b", 64'(out_if.tlast), 64'd1);
        @(negedge clk);
        check("sparse_idle", 64'(out_if.tvalid), 64'd0);
        @(posedge clk);
        #1;
        // Null non-tlast beat is swallowed
        drive_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b0, 1'b0);
        wait_accept("null");
        in_if.tvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("null_no_output", 64'(out_if.tvalid), 64'd0);
            check("null_ready", 64'(in_if.tready), 64'd1);
        end
        @(posedge clk);
        #1;
`endif

        // Random beats under 50% output backpressure
        sent = 0;
        for (int c = 0; c < 30000 && sent < 1000; c++) begin
            @(negedge clk);
            acc = in_if.tvalid && in_if.tready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (!in_if.tvalid || acc) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0)
                    drive_beat({$urandom, $urandom},
                               ($urandom_range(0, 9) < 6) ? 8'hFF : 8'($urandom),
                               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                else
                    in_if.tvalid = 1'b0;
            end
            out_if.tready = 1'($urandom_range(0, 1));
        end
        check("random_beats_sent", 64'(sent), 64'd1000);
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        wait_drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
